// File: rtl/seq_multiplier_param.sv
// Parametrised iterative shift-add multiplier with a runtime signed/unsigned mode.
// Each busy cycle retires BITS_PER_CYCLE multiplier bits. The product is formed on
// operand magnitudes and then sign-corrected. Overflow is flagged when the exact
// product does not fit in RES_WIDTH bits.
//
// Handshake: rdy=1 only in IDLE. A start happens on a rising edge where rdy=1 and
// en=1; op1/op2/sgn are captured on that edge and ignored from then on. en is ignored
// while rdy=0. val is high for exactly the one DONE cycle, K+1 edges after the start
// edge (counting the start edge as the first). res/overflow change only on the edge
// into DONE or on reset, and hold in between.
module seq_multiplier_param #(
    parameter int WIDTH          = 32,
    parameter int RES_WIDTH      = 2*WIDTH,
    parameter int BITS_PER_CYCLE = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 en,
    input  logic                 sgn,
    input  logic [WIDTH-1:0]     op1,
    input  logic [WIDTH-1:0]     op2,
    output logic                 rdy,
    output logic                 val,
    output logic [RES_WIDTH-1:0] res,
    output logic                 overflow
);

    localparam int PW    = 2*WIDTH;
    localparam int K     = WIDTH / BITS_PER_CYCLE;
    localparam int CNT_W = (K > 1) ? $clog2(K) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [PW-1:0]        acc_q;
    logic [PW-1:0]        mcand_q;    // |op1|, pre-shifted to the current digit position
    logic [WIDTH-1:0]     mplr_q;     // |op2|, remaining digits, LSB first
    logic [CNT_W-1:0]     cnt_q;
    logic                 sgn_q;
    logic                 neg_q;
    logic [RES_WIDTH-1:0] res_q;
    logic                 ovf_q;

    logic [WIDTH-1:0]     op1_mag, op2_mag;
    logic [PW-1:0]        partial, acc_next, prod, prod_hi_u, prod_hi_s;
    logic                 ovf_next;
    logic                 last_iter;

    assign last_iter = (cnt_q == CNT_W'(K-1));

    // State register; reset aborts any operation in flight.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic and handshake outputs.
    always_comb begin
        state_d = state_q;
        rdy     = 1'b0;
        val     = 1'b0;
        case (state_q)
            S_IDLE: begin
                rdy = 1'b1;
                if (en) state_d = S_BUSY;
            end
            S_BUSY: begin
                if (last_iter) state_d = S_DONE;
            end
            S_DONE: begin
                val     = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Operand magnitudes, next partial sum, sign-corrected product and overflow.
    always_comb begin
        op1_mag   = (sgn && op1[WIDTH-1]) ? -op1 : op1;
        op2_mag   = (sgn && op2[WIDTH-1]) ? -op2 : op2;
        partial   = mcand_q * {{(PW-BITS_PER_CYCLE){1'b0}}, mplr_q[BITS_PER_CYCLE-1:0]};
        acc_next  = acc_q + partial;
        // Negating a zero magnitude yields zero, so -0 never appears.
        prod      = neg_q ? -acc_next : acc_next;
        // Unsigned: any bit at or above RES_WIDTH means the product does not fit.
        prod_hi_u = prod >> RES_WIDTH;
        // Signed: bits RES_WIDTH-1 and up must all equal the sign bit.
        prod_hi_s = $signed(prod) >>> (RES_WIDTH-1);
        if (sgn_q) begin
            ovf_next = !((prod_hi_s == '0) || (prod_hi_s == '1));
        end else begin
            ovf_next = (prod_hi_u != '0);
        end
    end

    // Datapath: capture on start, accumulate in BUSY, latch the result on the last step.
    always_ff @(posedge clk) begin
        if (!reset) begin
            acc_q   <= '0;
            mcand_q <= '0;
            mplr_q  <= '0;
            cnt_q   <= '0;
            sgn_q   <= 1'b0;
            neg_q   <= 1'b0;
            res_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (en) begin
                        mcand_q <= {{WIDTH{1'b0}}, op1_mag};
                        mplr_q  <= op2_mag;
                        acc_q   <= '0;
                        cnt_q   <= '0;
                        sgn_q   <= sgn;
                        neg_q   <= sgn & (op1[WIDTH-1] ^ op2[WIDTH-1]);
                    end
                end
                S_BUSY: begin
                    acc_q   <= acc_next;
                    mcand_q <= mcand_q << BITS_PER_CYCLE;
                    mplr_q  <= mplr_q >> BITS_PER_CYCLE;
                    cnt_q   <= cnt_q + CNT_W'(1);
                    if (last_iter) begin
                        res_q <= prod[RES_WIDTH-1:0];
                        ovf_q <= ovf_next;
                    end
                end
                default: ;
            endcase
        end
    end

    assign res      = res_q;
    assign overflow = ovf_q;

endmodule

// File: tb/tb_seq_multiplier_param.sv
// Directed bench for seq_multiplier_param: a default-parameter instance (K=2) and an
// 8x8->8 instance with one bit per cycle (K=8). Expected values are hand-computed.
module tb_seq_multiplier_param;

  logic        clk;
  logic        reset;

  // default instance: WIDTH=32, RES_WIDTH=64, BITS_PER_CYCLE=16
  logic        en32, sgn32, rdy32, val32, ovf32;
  logic [31:0] op1_32, op2_32;
  logic [63:0] res32;

  // narrow instance: WIDTH=8, RES_WIDTH=8, BITS_PER_CYCLE=1
  logic        en8, sgn8, rdy8, val8, ovf8;
  logic [7:0]  op1_8, op2_8;
  logic [7:0]  res8;

  int total;
  int bad;

  seq_multiplier_param u32 (
    .clk(clk), .reset(reset), .en(en32), .sgn(sgn32),
    .op1(op1_32), .op2(op2_32),
    .rdy(rdy32), .val(val32), .res(res32), .overflow(ovf32)
  );

  seq_multiplier_param #(.WIDTH(8), .RES_WIDTH(8), .BITS_PER_CYCLE(1)) u8 (
    .clk(clk), .reset(reset), .en(en8), .sgn(sgn8),
    .op1(op1_8), .op2(op2_8),
    .rdy(rdy8), .val(val8), .res(res8), .overflow(ovf8)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // advance one rising edge, then settle before sampling or driving
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One operation on the default instance; val must appear after edge K=2.
  task automatic run32(input logic s, input logic [31:0] a, input logic [31:0] b,
                       input logic [63:0] exp_res, input logic exp_ovf, input string tag);
    int   n;
    logic rdy_low;
    sgn32 = s; op1_32 = a; op2_32 = b; en32 = 1'b1;
    tick();
    en32 = 1'b0;
    op1_32 = $urandom; op2_32 = $urandom; sgn32 = $urandom_range(0, 1);
    n = 0;
    rdy_low = 1'b1;
    while (!val32 && n < 20) begin
      if (rdy32) rdy_low = 1'b0;
      tick();
      n++;
    end
    if (rdy32) rdy_low = 1'b0;
    check({tag, "_latency"}, 64'(n), 64'd2);
    check({tag, "_res"}, res32, exp_res);
    check({tag, "_ovf"}, {63'd0, ovf32}, {63'd0, exp_ovf});
    check({tag, "_rdy_low"}, {63'd0, rdy_low}, 64'd1);
    tick();
    check({tag, "_val_pulse"}, {62'd0, val32, rdy32}, 64'd1);
  endtask

  // One operation on the narrow instance; val must appear after edge K=8.
  task automatic run8(input logic s, input logic [7:0] a, input logic [7:0] b,
                      input logic [7:0] exp_res, input logic exp_ovf, input string tag);
    int n;
    sgn8 = s; op1_8 = a; op2_8 = b; en8 = 1'b1;
    tick();
    en8 = 1'b0;
    op1_8 = 8'($urandom); op2_8 = 8'($urandom);
    n = 0;
    while (!val8 && n < 40) begin
      tick();
      n++;
    end
    check({tag, "_latency"}, 64'(n), 64'd8);
    check({tag, "_res"}, {56'd0, res8}, {56'd0, exp_res});
    check({tag, "_ovf"}, {63'd0, ovf8}, {63'd0, exp_ovf});
    tick();
    check({tag, "_val_pulse"}, {62'd0, val8, rdy8}, 64'd1);
  endtask

  initial begin
    logic seen_val;
    total = 0;
    bad   = 0;
    reset = 1'b0;
    en32 = 1'b0; sgn32 = 1'b0; op1_32 = '0; op2_32 = '0;
    en8  = 1'b0; sgn8  = 1'b0; op1_8  = '0; op2_8  = '0;
    repeat (3) tick();

    // reset state
    check("rst_rdy32", {63'd0, rdy32}, 64'd1);
    check("rst_val32", {63'd0, val32}, 64'd0);
    check("rst_res32", res32, 64'd0);
    check("rst_ovf32", {63'd0, ovf32}, 64'd0);
    check("rst_rdy8",  {63'd0, rdy8}, 64'd1);
    check("rst_res8",  {56'd0, res8}, 64'd0);
    reset = 1'b1;
    tick();

    // default parameters
    run32(1'b0, 32'd48, 32'd56, 64'd2688, 1'b0, "u_48x56");
    run32(1'b1, 32'hFFFF_FFF9, 32'd3, 64'hFFFF_FFFF_FFFF_FFEB, 1'b0, "s_m7x3");
    run32(1'b1, 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000, 1'b0, "s_minsq");
    run32(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, 1'b0, "u_maxsq");
    run32(1'b1, 32'd0, 32'hFFFF_FFFB, 64'd0, 1'b0, "s_zero");

    // narrow instance, unsigned
    run8(1'b0, 8'd15, 8'd17, 8'd255, 1'b0, "n_u_15x17");
    run8(1'b0, 8'd16, 8'd16, 8'd0,   1'b1, "n_u_16x16");
    // narrow instance, signed
    run8(1'b1, 8'h80, 8'h01, 8'h80, 1'b0, "n_s_m128x1");
    run8(1'b1, 8'h80, 8'hFF, 8'h80, 1'b1, "n_s_m128xm1");
    run8(1'b1, 8'h0C, 8'hF5, 8'h7C, 1'b1, "n_s_12xm11");

    // en held high: accepts at edges 0, 4, 8; vals after edges 2, 6, 10
    sgn32 = 1'b0; op1_32 = 32'd3; op2_32 = 32'd5; en32 = 1'b1;
    tick();                                   // edge 0: accept 3x5
    op1_32 = 32'd1000; op2_32 = 32'd1000;
    tick();                                   // edge 1
    check("b2b_busy_val", {62'd0, val32, rdy32}, 64'd0);
    tick();                                   // edge 2
    check("b2b_a_val", {63'd0, val32}, 64'd1);
    check("b2b_a_res", res32, 64'd15);
    tick();                                   // edge 3: IDLE
    check("b2b_a_idle", {62'd0, val32, rdy32}, 64'd1);
    tick();                                   // edge 4: accept 1000x1000
    op1_32 = 32'hFFFF_FFFF; op2_32 = 32'd2;
    check("b2b_b_rdy", {63'd0, rdy32}, 64'd0);
    tick(); tick();                           // edge 6
    check("b2b_b_val", {63'd0, val32}, 64'd1);
    check("b2b_b_res", res32, 64'd1_000_000);
    tick(); tick();                           // edge 8: accept 0xFFFFFFFF x 2
    en32 = 1'b0;
    op1_32 = 32'd77; op2_32 = 32'd77;
    tick(); tick();                           // edge 10
    check("b2b_c_val", {63'd0, val32}, 64'd1);
    check("b2b_c_res", res32, 64'h1_FFFF_FFFE);
    tick();
    check("b2b_c_idle", {62'd0, val32, rdy32}, 64'd1);

    // abort in mid-BUSY
    sgn32 = 1'b0; op1_32 = 32'd100; op2_32 = 32'd100; en32 = 1'b1;
    tick();                                   // accept
    en32 = 1'b0;
    tick();                                   // first iteration
    reset = 1'b0;
    tick();                                   // reset sampled
    check("abort_rdy", {63'd0, rdy32}, 64'd1);
    check("abort_val", {63'd0, val32}, 64'd0);
    check("abort_res", res32, 64'd0);
    check("abort_ovf", {63'd0, ovf32}, 64'd0);
    reset = 1'b1;
    seen_val = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (val32) seen_val = 1'b1;
      tick();
    end
    check("abort_no_val", {63'd0, seen_val}, 64'd0);
    run32(1'b0, 32'd7, 32'd9, 64'd63, 1'b0, "post_abort");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
